// File: rtl/aes_pkg.sv
// Shared AES primitives for the iterative core: S-box, round constants,
// MixColumns arithmetic, FSM encoding and round-count helper.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } fsm_t;

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic int unsigned NR_OF(input int unsigned key_bits);
        return (key_bits == 128) ? 10 : 14;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Round constant for key-schedule generation k (1-based).
    function automatic logic [7:0] rcon(input logic [3:0] k);
        logic [7:0] r;
        case (k)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // MixColumns on one column, row 0 in the MSB.
    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] r0, r1, r2, r3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        r0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        r1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        r2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        r3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return {r0, r1, r2, r3};
    endfunction

endpackage

// File: rtl/aes_iter_core_if.sv
// Plaintext/key input and ciphertext output handshake bundle of aes_iter_core.
interface aes_iter_core_if #(
    parameter int unsigned KEY_BITS = 256
);
    logic                in_valid;
    logic                in_ready;
    logic [127:0]        in_state;
    logic [KEY_BITS-1:0] in_key;
    logic                out_valid;
    logic                out_ready;
    logic [127:0]        out_data;
    logic                busy;

    // Block-mode controller side.
    modport master (
        output in_valid, in_state, in_key, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    // Cipher core side.
    modport slave (
        input  in_valid, in_state, in_key, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/aes_key_step.sv
// One on-the-fly key-schedule step: from the last Nk words of the expanded
// key produce the next four words, starting at word index word_idx.
module aes_key_step #(
    parameter int unsigned KEY_BITS = 256
) (
    input  logic [KEY_BITS-1:0] kwin,
    input  logic [5:0]          word_idx,
    output logic [127:0]        step_out
);
    import aes_pkg::*;

    localparam int unsigned NK   = KEY_BITS / 32;
    localparam logic [5:0]  NK_W = 6'(NK);

    logic        type_a;
    logic [3:0]  rcon_k;
    logic [31:0] prev;
    logic [31:0] temp;
    logic [31:0] nw [4];

    assign type_a = ((word_idx & (NK_W - 6'd1)) == '0);
    assign rcon_k = 4'(word_idx / NK_W);
    assign prev   = kwin[31:0];

    // Type A (rotate+sub+rcon) or type B (sub only), then chain four words.
    always_comb begin
        if (type_a) begin
            temp = sub_word({prev[23:0], prev[31:24]}) ^ {rcon(rcon_k), 24'h0};
        end else begin
            temp = sub_word(prev);
        end
        nw[0] = kwin[KEY_BITS-1 -: 32] ^ temp;
        for (int unsigned j = 1; j < 4; j++) begin
            nw[j] = kwin[KEY_BITS-1-32*j -: 32] ^ nw[j-1];
        end
        step_out = {nw[0], nw[1], nw[2], nw[3]};
    end

endmodule

// File: rtl/aes_iter_core.sv
// Iterative AES encryption core: one full round per clock with the key
// schedule expanded alongside; 128- or 256-bit keys by parameter.
module aes_iter_core #(
    parameter int unsigned KEY_BITS = 256
) (
    input  logic         clk,
    input  logic         rst,
    aes_iter_core_if.slave bus
);
    import aes_pkg::*;

    localparam int unsigned NR   = NR_OF(KEY_BITS);
    localparam logic [3:0]  NR_W = 4'(NR);

    if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key
        $fatal(1, "aes_iter_core: KEY_BITS must be 128 or 256");
    end

    fsm_t                state_q, state_d;
    logic [3:0]          rnd_q;
    logic [127:0]        s_q;
    logic [KEY_BITS-1:0] kwin_q;
    logic [KEY_BITS-1:0] kwin_next;
    logic [127:0]        step_out;
    logic [127:0]        rk;
    logic [5:0]          word_idx;
    logic [127:0]        sr_flat;
    logic [127:0]        mixed;
    logic [127:0]        round_out;
    logic [7:0]          sb [16];
    logic [7:0]          sr [16];
    logic                accept;
    logic                last_round;

    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_data  = s_q;
    assign bus.busy      = (state_q != IDLE);
    assign accept        = bus.in_valid && bus.in_ready;
    assign last_round    = (rnd_q == NR_W);

    // AES-256 keeps an 8-word window whose upper half was consumed last
    // round; AES-128 uses the freshly generated words directly.
    if (KEY_BITS == 256) begin : g_k256
        assign word_idx  = {rnd_q, 2'b00} + 6'd4;
        assign rk        = kwin_q[KEY_BITS-129 -: 128];
        assign kwin_next = {kwin_q[KEY_BITS-129:0], step_out};
    end else begin : g_k128
        assign word_idx  = {rnd_q, 2'b00};
        assign rk        = step_out;
        assign kwin_next = step_out;
    end

    aes_key_step #(
        .KEY_BITS (KEY_BITS)
    ) u_key_step (
        .kwin     (kwin_q),
        .word_idx (word_idx),
        .step_out (step_out)
    );

    // Round datapath: SubBytes, ShiftRows, MixColumns (skipped in the last round), AddRoundKey.
    always_comb begin
        for (int unsigned k = 0; k < 16; k++) begin
            sb[k] = sbox(s_q[127-8*k -: 8]);
        end
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                sr[r+4*c] = sb[r + 4*((c+r)%4)];
            end
        end
        sr_flat = '0;
        for (int unsigned k = 0; k < 16; k++) begin
            sr_flat[127-8*k -: 8] = sr[k];
        end
        mixed = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            mixed[127-32*c -: 32] = mix_column(sr_flat[127-32*c -: 32]);
        end
        round_out = (last_round ? sr_flat : mixed) ^ rk;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: accept from IDLE, leave ROUND after round NR, drain DONE on handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)        state_d = ROUND;
            ROUND:   if (last_round)    state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    // Cipher state, key window and round counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q    <= '0;
            kwin_q <= '0;
            rnd_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        s_q    <= bus.in_state ^ bus.in_key[KEY_BITS-1 -: 128];
                        kwin_q <= bus.in_key;
                        rnd_q  <= 4'd1;
                    end
                end
                ROUND: begin
                    s_q    <= round_out;
                    kwin_q <= kwin_next;
                    rnd_q  <= rnd_q + 4'd1;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        rnd_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_iter_core.sv
// Self-checking bench for aes_iter_core: one AES-128 and one AES-256 instance,
// checked against known-answer vectors and an independent AES reference model.
module tb_aes_iter_core;

    logic         clk;
    logic         rst;
    logic [1:0]   in_valid_r;
    logic [1:0]   out_ready_r;
    logic [127:0] in_state_r [2];
    logic [255:0] in_key_r [2];
    logic [1:0]   in_ready_w;
    logic [1:0]   out_valid_w;
    logic [1:0]   busy_w;
    logic [127:0] out_data_w [2];

    int errors;
    int checks;

    logic [127:0] sbq0 [$];
    logic [127:0] sbq1 [$];
    logic [7:0]   tsbox [256];

    aes_iter_core_if #(.KEY_BITS(128)) if128 ();
    aes_iter_core_if #(.KEY_BITS(256)) if256 ();

    assign if128.in_valid  = in_valid_r[0];
    assign if128.in_state  = in_state_r[0];
    assign if128.in_key    = in_key_r[0][255:128];
    assign if128.out_ready = out_ready_r[0];
    assign if256.in_valid  = in_valid_r[1];
    assign if256.in_state  = in_state_r[1];
    assign if256.in_key    = in_key_r[1];
    assign if256.out_ready = out_ready_r[1];

    assign in_ready_w    = {if256.in_ready, if128.in_ready};
    assign out_valid_w   = {if256.out_valid, if128.out_valid};
    assign busy_w        = {if256.busy, if128.busy};
    assign out_data_w[0] = if128.out_data;
    assign out_data_w[1] = if256.out_data;

    aes_iter_core #(.KEY_BITS(128)) dut128 (
        .clk (clk),
        .rst (rst),
        .bus (if128.slave)
    );

    aes_iter_core #(.KEY_BITS(256)) dut256 (
        .clk (clk),
        .rst (rst),
        .bus (if256.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box derived from GF(2^8) inversion plus the affine transform.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h01;
            if (x == 0) inv = 8'h00;
            else for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
            tsbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                       ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] tsub(input logic [31:0] w);
        return {tsbox[w[31:24]], tsbox[w[23:16]], tsbox[w[15:8]], tsbox[w[7:0]]};
    endfunction

    // Full-schedule AES; key word 0 in key[255:224], nk = 4 or 8.
    function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input logic [255:0] key, input int nk);
        logic [31:0]  w [60];
        logic [7:0]   st [16];
        logic [7:0]   tmp [16];
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [31:0]  t;
        logic [127:0] res;
        int nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = tsub({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = tsub(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int k = 0; k < 16; k++) st[k] = pt[127-8*k -: 8] ^ w[k/4][31-8*(k%4) -: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int k = 0; k < 16; k++) tmp[k] = tsbox[st[k]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    st[row+4*c] = tmp[row + 4*((c+row)%4)];
            if (r != nr) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = st[4*c]; a1 = st[4*c+1]; a2 = st[4*c+2]; a3 = st[4*c+3];
                    st[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    st[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    st[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    st[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            for (int k = 0; k < 16; k++) st[k] = st[k] ^ w[4*r + k/4][31-8*(k%4) -: 8];
        end
        for (int k = 0; k < 16; k++) res[127-8*k -: 8] = st[k];
        return res;
    endfunction

    // ---------------- scoreboard queues ----------------
    task automatic push_exp(input int d, input logic [127:0] v);
        if (d == 0) sbq0.push_back(v);
        else        sbq1.push_back(v);
    endtask

    task automatic pop_exp(input int d, output logic [127:0] v, output bit ok);
        v  = '0;
        ok = 1'b0;
        if (d == 0 && sbq0.size() > 0) begin v = sbq0.pop_front(); ok = 1'b1; end
        if (d == 1 && sbq1.size() > 0) begin v = sbq1.pop_front(); ok = 1'b1; end
    endtask

    // Present a block and hold in_valid until the accept edge; returns at accept edge + 1.
    task automatic send_block(input int d, input logic [127:0] pt, input logic [255:0] key);
        int unsigned waited;
        waited = 0;
        in_state_r[d] = pt;
        in_key_r[d]   = key;
        in_valid_r[d] = 1'b1;
        @(negedge clk);
        while (!in_ready_w[d] && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (in_ready_w[d] !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout dut%0d: in_ready=%b required 1", d, in_ready_w[d]);
        end
        @(posedge clk); #1;
        in_valid_r[d] = 1'b0;
    endtask

    // Count edges until out_valid is seen (sampled 1 after each edge).
    task automatic wait_valid(input int d, input int unsigned limit, output int unsigned n);
        n = 0;
        while (!out_valid_w[d] && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (in_ready_w[d] !== 1'b0) begin errors++; $display("FAIL reset_in_ready dut%0d: got %b required 0", d, in_ready_w[d]); end
            checks++;
            if (busy_w[d] !== 1'b0) begin errors++; $display("FAIL reset_busy dut%0d: got %b required 0", d, busy_w[d]); end
            checks++;
            if (out_valid_w[d] !== 1'b0) begin errors++; $display("FAIL reset_out_valid dut%0d: got %b required 0", d, out_valid_w[d]); end
            checks++;
            if (out_data_w[d] !== 128'h0) begin errors++; $display("FAIL reset_out_data dut%0d: got %h required 0", d, out_data_w[d]); end
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (in_ready_w !== 2'b11) begin errors++; $display("FAIL release_in_ready: got %b required 11", in_ready_w); end
    endtask

    task automatic test_vec(input int d);
        logic [255:0] key;
        logic [127:0] pt, exp_v;
        bit ok;
        int unsigned n, nr;
        pt = 128'h00112233445566778899aabbccddeeff;
        if (d == 0) begin
            key = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
            nr  = 10;
            push_exp(d, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        end else begin
            key = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
            nr  = 14;
            push_exp(d, 128'h8ea2b7ca516745bfeafc49904b496089);
        end
        send_block(d, pt, key);
        checks++;
        if (busy_w[d] !== 1'b1) begin errors++; $display("FAIL busy_after_accept dut%0d: got %b required 1", d, busy_w[d]); end
        wait_valid(d, 40, n);
        checks++;
        if (n != nr) begin errors++; $display("FAIL latency dut%0d: got %0d edges required %0d", d, n, nr); end
        pop_exp(d, exp_v, ok);
        checks++;
        if (!ok || out_data_w[d] !== exp_v) begin errors++; $display("FAIL kat_data dut%0d: got %h required %h", d, out_data_w[d], exp_v); end
        out_ready_r[d] = 1'b1;
        @(posedge clk); #1;
        out_ready_r[d] = 1'b0;
        checks++;
        if (out_valid_w[d] !== 1'b0) begin errors++; $display("FAIL kat_drain_valid dut%0d: got %b required 0", d, out_valid_w[d]); end
        checks++;
        if (in_ready_w[d] !== 1'b1) begin errors++; $display("FAIL kat_drain_ready dut%0d: got %b required 1", d, in_ready_w[d]); end
    endtask

    task automatic test_stall();
        logic [255:0] key;
        logic [127:0] pt, exp_v;
        bit ok;
        int unsigned n;
        key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        pt  = {$urandom, $urandom, $urandom, $urandom};
        push_exp(1, ref_encrypt(pt, key, 8));
        send_block(1, pt, key);
        wait_valid(1, 40, n);
        pop_exp(1, exp_v, ok);
        checks++;
        if (!ok || out_data_w[1] !== exp_v) begin errors++; $display("FAIL stall_data: got %h required %h", out_data_w[1], exp_v); end
        for (int c = 0; c < 20; c++) begin
            in_valid_r[1] = 1'($urandom_range(0, 1));
            in_state_r[1] = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            checks++;
            if (out_valid_w[1] !== 1'b1) begin errors++; $display("FAIL stall_valid cycle %0d: got %b required 1", c, out_valid_w[1]); end
            checks++;
            if (out_data_w[1] !== exp_v) begin errors++; $display("FAIL stall_hold cycle %0d: got %h required %h", c, out_data_w[1], exp_v); end
            checks++;
            if (in_ready_w[1] !== 1'b0) begin errors++; $display("FAIL stall_in_ready cycle %0d: got %b required 0", c, in_ready_w[1]); end
            @(posedge clk); #1;
        end
        in_valid_r[1]  = 1'b0;
        out_ready_r[1] = 1'b1;
        @(posedge clk); #1;
        out_ready_r[1] = 1'b0;
        checks++;
        if (out_valid_w[1] !== 1'b0) begin errors++; $display("FAIL stall_release_valid: got %b required 0", out_valid_w[1]); end
        checks++;
        if (in_ready_w[1] !== 1'b1) begin errors++; $display("FAIL stall_release_ready: got %b required 1", in_ready_w[1]); end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy_w[1] !== 1'b0) begin errors++; $display("FAIL stall_no_restart: busy=%b required 0", busy_w[1]); end
    endtask

    task automatic test_reset_mid();
        int unsigned seen;
        send_block(1, 128'h00112233445566778899aabbccddeeff,
                   256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
        repeat (6) @(posedge clk);
        #2;
        checks++;
        if (busy_w[1] !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b required 1", busy_w[1]); end
        rst = 1'b1;
        #1;
        checks++;
        if (busy_w[1] !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b required 0", busy_w[1]); end
        checks++;
        if (out_valid_w[1] !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b required 0", out_valid_w[1]); end
        checks++;
        if (in_ready_w[1] !== 1'b0) begin errors++; $display("FAIL midrst_in_ready: got %b required 0", in_ready_w[1]); end
        checks++;
        if (out_data_w[1] !== 128'h0) begin errors++; $display("FAIL midrst_out_data: got %h required 0", out_data_w[1]); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (in_ready_w[1] !== 1'b1) begin errors++; $display("FAIL midrst_release_ready: got %b required 1", in_ready_w[1]); end
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (out_valid_w[1] || busy_w[1]) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL midrst_discard: got %0d active cycles required 0", seen); end
        @(posedge clk); #1;
        test_vec(1);
    endtask

    task automatic test_random(input int d, input int n);
        int got;
        got = 0;
        fork
            begin
                logic [127:0] pt;
                logic [255:0] key;
                for (int b = 0; b < n; b++) begin
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    pt  = {$urandom, $urandom, $urandom, $urandom};
                    key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                    push_exp(d, ref_encrypt(pt, key, (d == 0) ? 4 : 8));
                    send_block(d, pt, key);
                end
            end
            begin
                logic [127:0] exp_v;
                bit ok;
                int budget;
                budget = 0;
                while (got < n && budget < n * 80) begin
                    @(posedge clk); #1;
                    out_ready_r[d] = ($urandom_range(0, 2) != 0);
                    @(negedge clk);
                    if (out_valid_w[d] && out_ready_r[d]) begin
                        pop_exp(d, exp_v, ok);
                        checks++;
                        if (!ok || out_data_w[d] !== exp_v) begin
                            errors++;
                            $display("FAIL random_data dut%0d block %0d: got %h required %h", d, got, out_data_w[d], exp_v);
                        end
                        got++;
                    end
                    budget++;
                end
                @(posedge clk); #1;
                out_ready_r[d] = 1'b0;
            end
        join
        checks++;
        if (got != n) begin errors++; $display("FAIL random_count dut%0d: got %0d outputs required %0d", d, got, n); end
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        rst         = 1'b1;
        in_valid_r  = '0;
        out_ready_r = '0;
        for (int d = 0; d < 2; d++) begin
            in_state_r[d] = '0;
            in_key_r[d]   = '0;
        end
        build_sbox();
        test_reset();
        test_vec(0);
        test_vec(1);
        test_stall();
        test_reset_mid();
        test_random(0, 40);
        test_random(1, 40);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
